// File: rtl/slot_select_sequencer.sv
// Purpose: registered one-hot slot-select sequencer for I2S receive word assembly (optional macro SLOT_SEQ_AUTO_WRAP_EN).
// Latency: 1 clk_i from sync_i/adv_i/abort_i to every output; all outputs come from registers.
// Backpressure: none; accepts an adv_i strobe every cycle, and adv_i in IDLE is dropped.
module slot_select_sequencer #(
    parameter int SLOT_COUNT  = 32,
    parameter int INDEX_WIDTH = $clog2(SLOT_COUNT),
    parameter int MSB_FIRST   = 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   sync_i,
    input  logic                   adv_i,
    input  logic                   abort_i,
    output logic [SLOT_COUNT-1:0]  sel_o,
    output logic [INDEX_WIDTH-1:0] idx_o,
    output logic                   active_o,
    output logic                   last_o,
    output logic                   done_o
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // First slot of a word and the slot that completes it.
    localparam logic [INDEX_WIDTH-1:0] IDX_START = (MSB_FIRST != 0) ? INDEX_WIDTH'(SLOT_COUNT - 1) : '0;
    localparam logic [INDEX_WIDTH-1:0] IDX_TERM  = (MSB_FIRST != 0) ? '0 : INDEX_WIDTH'(SLOT_COUNT - 1);
    localparam logic [SLOT_COUNT-1:0]  SEL_ONE   = {{(SLOT_COUNT-1){1'b0}}, 1'b1};

    logic [0:0]             state;
    logic [INDEX_WIDTH-1:0] idx;
    logic [INDEX_WIDTH-1:0] idx_step;
    logic [SLOT_COUNT-1:0]  sel;
    logic                   done;

    // Neighbouring index one step toward the terminal slot.
    always_comb begin
        idx_step = idx;
        if (MSB_FIRST != 0) begin
            idx_step = idx - 1'b1;
        end else begin
            idx_step = idx + 1'b1;
        end
    end

    // State, index and one-hot select; priority is reset, sync, abort, advance.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
            idx   <= '0;
            sel   <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (sync_i) begin
                // A simultaneous adv_i is dropped: the first bit lands on the next strobe.
                state <= ST_RUN;
                idx   <= IDX_START;
                sel   <= SEL_ONE << IDX_START;
            end else if (abort_i) begin
                // Index is left where it was so it can be inspected after an abort.
                state <= ST_IDLE;
                sel   <= '0;
            end else if (adv_i && (state == ST_RUN)) begin
                if (idx == IDX_TERM) begin
                    done <= 1'b1;
`ifdef SLOT_SEQ_AUTO_WRAP_EN
                    // Continuous framing: roll straight into the next word.
                    idx <= IDX_START;
                    sel <= SEL_ONE << IDX_START;
`else
                    // Single word: wait for a fresh sync_i.
                    state <= ST_IDLE;
                    sel   <= '0;
`endif
                end else begin
                    idx <= idx_step;
                    sel <= SEL_ONE << idx_step;
                end
            end
        end
    end

    assign sel_o    = sel;
    assign idx_o    = idx;
    assign active_o = (state == ST_RUN);
    assign last_o   = (state == ST_RUN) && (idx == IDX_TERM);
    assign done_o   = done;

endmodule

// File: tb/tb_slot_select_sequencer.sv
// Purpose: directed scoreboard bench for slot_select_sequencer (32-slot MSB-first and 24-slot LSB-first instances).
// Latency: expected values are queued when a stimulus cycle is driven and checked 1 cycle later.
// Backpressure: not applicable; the monitor drains one expected record per clock per instance.
module tb_slot_select_sequencer;

    typedef struct {
        logic [63:0] sel;
        logic [5:0]  idx;
        logic        act;
        logic        last;
        logic        done;
    } exp_t;

    logic clk;

    logic        rst_a, sync_a, adv_a, abort_a;
    logic [31:0] sel_a;
    logic [4:0]  idx_a;
    logic        act_a, last_a, done_a;

    logic        rst_b, sync_b, adv_b, abort_b;
    logic [23:0] sel_b;
    logic [4:0]  idx_b;
    logic        act_b, last_b, done_b;

    exp_t qa[$];
    exp_t qb[$];

    int errors = 0;
    int checks = 0;

    slot_select_sequencer #(.SLOT_COUNT(32), .MSB_FIRST(1)) dut_a (
        .clk_i(clk), .rst_i(rst_a), .sync_i(sync_a), .adv_i(adv_a), .abort_i(abort_a),
        .sel_o(sel_a), .idx_o(idx_a), .active_o(act_a), .last_o(last_a), .done_o(done_a)
    );

    slot_select_sequencer #(.SLOT_COUNT(24), .MSB_FIRST(0)) dut_b (
        .clk_i(clk), .rst_i(rst_b), .sync_i(sync_b), .adv_i(adv_b), .abort_i(abort_b),
        .sel_o(sel_b), .idx_o(idx_b), .active_o(act_b), .last_o(last_b), .done_o(done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected output record: sel is one-hot at idx only while running.
    function automatic exp_t mk(input bit act, input int idx, input bit done, input int term);
        exp_t e;
        e.sel  = act ? (64'd1 << idx) : 64'd0;
        e.idx  = 6'(idx);
        e.act  = act;
        e.last = act && (idx == term);
        e.done = done;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
        end
    endtask

    task automatic step_a(input logic r, input logic s, input logic v, input logic ab, input exp_t e);
        @(negedge clk);
        rst_a = r; sync_a = s; adv_a = v; abort_a = ab;
        qa.push_back(e);
    endtask

    task automatic step_b(input logic r, input logic s, input logic v, input logic ab, input exp_t e);
        @(negedge clk);
        rst_b = r; sync_b = s; adv_b = v; abort_b = ab;
        qb.push_back(e);
    endtask

    // Monitor: one record per instance per cycle, sampled 1 time unit after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (qa.size() != 0) begin
                e = qa.pop_front();
                chk("a_sel",    64'(sel_a),  e.sel);
                chk("a_idx",    64'(idx_a),  64'(e.idx));
                chk("a_active", 64'(act_a),  64'(e.act));
                chk("a_last",   64'(last_a), 64'(e.last));
                chk("a_done",   64'(done_a), 64'(e.done));
                if (act_a === 1'b1) chk("a_onehot", 64'($onehot(sel_a)), 64'd1);
            end
            if (qb.size() != 0) begin
                e = qb.pop_front();
                chk("b_sel",    64'(sel_b),  e.sel);
                chk("b_idx",    64'(idx_b),  64'(e.idx));
                chk("b_active", 64'(act_b),  64'(e.act));
                chk("b_last",   64'(last_b), 64'(e.last));
                chk("b_done",   64'(done_b), 64'(e.done));
                if (act_b === 1'b1) chk("b_onehot", 64'($onehot(sel_b)), 64'd1);
            end
        end
    end

    initial begin
        int cur;
        int gap;
        rst_a = 1'b1; sync_a = 1'b0; adv_a = 1'b0; abort_a = 1'b0;
        rst_b = 1'b1; sync_b = 1'b0; adv_b = 1'b0; abort_b = 1'b0;

        // ---------------- instance A: 32 slots, MSB first ----------------
        step_a(1, 0, 0, 0, mk(0, 0, 0, 0));
        step_a(1, 0, 0, 0, mk(0, 0, 0, 0));
        step_a(0, 1, 0, 0, mk(1, 31, 0, 0));          // sel = 32'h8000_0000
        for (int k = 1; k < 32; k++)
            step_a(0, 0, 1, 0, mk(1, 31 - k, 0, 0));  // last only at idx 0
`ifdef SLOT_SEQ_AUTO_WRAP_EN
        step_a(0, 0, 1, 0, mk(1, 31, 1, 0));
        step_a(0, 0, 0, 0, mk(1, 31, 0, 0));
`else
        step_a(0, 0, 1, 0, mk(0, 0, 1, 0));
        step_a(0, 0, 0, 0, mk(0, 0, 0, 0));
        step_a(0, 0, 1, 0, mk(0, 0, 0, 0));           // adv in IDLE ignored
`endif

        // Restart mid-word: sync with adv drops the adv, no done.
        step_a(0, 1, 0, 0, mk(1, 31, 0, 0));
        for (int k = 1; k <= 10; k++)
            step_a(0, 0, 1, 0, mk(1, 31 - k, 0, 0));
        step_a(0, 1, 1, 0, mk(1, 31, 0, 0));
        step_a(0, 0, 1, 0, mk(1, 30, 0, 0));

        // Abort after 5 more strobes: idx held, later adv ignored.
        for (int k = 1; k <= 5; k++)
            step_a(0, 0, 1, 0, mk(1, 30 - k, 0, 0));
        step_a(0, 0, 1, 1, mk(0, 25, 0, 0));
        for (int k = 0; k < 3; k++)
            step_a(0, 0, 1, 0, mk(0, 25, 0, 0));

        // sync beats abort.
        step_a(0, 1, 0, 1, mk(1, 31, 0, 0));

        // Reset alongside sync mid-word: reset wins.
        for (int k = 1; k <= 5; k++)
            step_a(0, 0, 1, 0, mk(1, 31 - k, 0, 0));
        step_a(1, 1, 1, 0, mk(0, 0, 0, 0));
        step_a(0, 0, 0, 0, mk(0, 0, 0, 0));

        // Sparse strobes with random gaps: select holds between strobes.
        step_a(0, 1, 0, 0, mk(1, 31, 0, 0));
        cur = 31;
        for (int s = 0; s < 8; s++) begin
            gap = int'($urandom_range(1, 3));
            for (int g = 0; g < gap; g++)
                step_a(0, 0, 0, 0, mk(1, cur, 0, 0));
            cur--;
            step_a(0, 0, 1, 0, mk(1, cur, 0, 0));
        end
        step_a(0, 0, 0, 0, mk(1, 23, 0, 0));

        // ---------------- instance B: 24 slots, LSB first ----------------
        step_b(1, 0, 0, 0, mk(0, 0, 0, 23));
        step_b(1, 0, 0, 0, mk(0, 0, 0, 23));
        step_b(0, 1, 0, 0, mk(1, 0, 0, 23));
        for (int k = 1; k <= 23; k++)
            step_b(0, 0, 1, 0, mk(1, k, 0, 23));      // ends at sel = 24'h80_0000, last = 1
`ifdef SLOT_SEQ_AUTO_WRAP_EN
        step_b(0, 0, 1, 0, mk(1, 0, 1, 23));
        step_b(0, 0, 0, 0, mk(1, 0, 0, 23));
`else
        step_b(0, 0, 1, 0, mk(0, 23, 1, 23));
        step_b(0, 0, 0, 0, mk(0, 23, 0, 23));
        step_b(0, 0, 1, 0, mk(0, 23, 0, 23));
`endif

        repeat (3) @(negedge clk);
        chk("qa_drained", 64'(qa.size()), 64'd0);
        chk("qb_drained", 64'(qb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
